// File: rtl/instr_mem_loader.sv
// instr_mem_loader: writer side of the instruction memory.
// Takes a byte stream over valid/ready, packs four bytes big-endian into a
// 32-bit word and writes it at byte address (word index * 4). While a load is
// running the CPU is held so it never fetches a half-loaded image.
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN adds a trailing checksum
// byte (XOR of all data bytes must cancel to 0x00) that is checked in CHK.
module instr_mem_loader #(
    parameter int DEPTH = 32,
    parameter int LEN_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_data_i,
    output logic             byte_ready_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic             busy_o,
    output logic             cpu_hold_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
`ifdef INSTR_LOADER_CHECKSUM_EN
        S_CHK   = 3'd3,
`endif
        S_DONE  = 3'd4
    } state_t;

    state_t           state_r;
    state_t           next_s;
    logic [LEN_W-1:0] len_r;
    logic [IDX_W-1:0] idx_r;
    logic [1:0]       cnt_r;
    logic [23:0]      shift_r;
    logic             accept_s;
    logic             len_bad_s;
    logic             last_word_s;
    logic             ready_next_s;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]       csum_r;
    logic             chk_got_r;
`endif

    assign accept_s    = byte_valid_i & byte_ready_o;
    assign len_bad_s   = (len_i == {LEN_W{1'b0}}) || (len_i > LEN_W'(DEPTH));
    assign last_word_s = ((LEN_W'(idx_r) + LEN_W'(1)) == len_r);

    // Ready is registered, so it is derived from the state we are about to enter;
    // in CHK it drops as soon as the single checksum byte has been taken.
`ifdef INSTR_LOADER_CHECKSUM_EN
    assign ready_next_s = (next_s == S_RECV) ||
                          ((next_s == S_CHK) && !accept_s && !chk_got_r);
`else
    assign ready_next_s = (next_s == S_RECV);
`endif

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_i) begin
                    next_s = len_bad_s ? S_DONE : S_RECV;
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_RECV: begin
                if (accept_s && (cnt_r == 2'd3)) begin
                    next_s = S_WRITE;
                end else begin
                    next_s = S_RECV;
                end
            end
            S_WRITE: begin
                if (last_word_s) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    next_s = S_CHK;
`else
                    next_s = S_DONE;
`endif
                end else begin
                    next_s = S_RECV;
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (chk_got_r) begin
                    next_s = S_DONE;
                end else begin
                    next_s = S_CHK;
                end
            end
`endif
            S_DONE:  next_s = S_IDLE;
            default: next_s = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; flags follow the next state so they
    // line up with the cycle the FSM actually spends in that state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byte_ready_o <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= 32'd0;
            mem_wdata_o  <= 32'd0;
            busy_o       <= 1'b0;
            cpu_hold_o   <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            len_r        <= {LEN_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            cnt_r        <= 2'd0;
            shift_r      <= 24'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_r       <= 8'h00;
            chk_got_r    <= 1'b0;
`endif
        end else begin
            byte_ready_o <= ready_next_s;
            mem_we_o     <= (next_s == S_WRITE);
            busy_o       <= (next_s != S_IDLE);
            cpu_hold_o   <= (next_s != S_IDLE);
            done_o       <= (next_s == S_DONE);
            case (state_r)
                S_IDLE: begin
                    if (start_i) begin
                        if (len_bad_s) begin
                            err_o <= 1'b1;
                        end else begin
                            err_o     <= 1'b0;
                            len_r     <= len_i;
                            idx_r     <= {IDX_W{1'b0}};
                            cnt_r     <= 2'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                            csum_r    <= 8'h00;
                            chk_got_r <= 1'b0;
`endif
                        end
                    end
                end
                S_RECV: begin
                    if (accept_s) begin
                        shift_r <= {shift_r[15:0], byte_data_i};
                        cnt_r   <= cnt_r + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        csum_r  <= csum_r ^ byte_data_i;
`endif
                        if (cnt_r == 2'd3) begin
                            mem_wdata_o <= {shift_r, byte_data_i};
                            mem_addr_o  <= {{(30-IDX_W){1'b0}}, idx_r, 2'b00};
                        end
                    end
                end
                S_WRITE: begin
                    idx_r <= idx_r + IDX_W'(1);
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (chk_got_r) begin
                        err_o <= (csum_r != 8'h00);
                    end else if (accept_s) begin
                        csum_r    <= csum_r ^ byte_data_i;
                        chk_got_r <= 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader. Expected writes are derived from
// the byte stream the bench generates (four bytes per word, first byte most
// significant, word k at address 4*k).
module tb_instr_mem_loader;

    localparam int DEPTH = 32;
    localparam int LEN_W = 6;
`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam int CSUM_EXTRA = 2;
`else
    localparam int CSUM_EXTRA = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             byte_valid = 1'b0;
    logic [7:0]       byte_data = 8'h00;
    logic             byte_ready;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             busy;
    logic             cpu_hold;
    logic             done;
    logic             err;

    instr_mem_loader #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .len_i        (len),
        .byte_valid_i (byte_valid),
        .byte_data_i  (byte_data),
        .byte_ready_o (byte_ready),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .busy_o       (busy),
        .cpu_hold_o   (cpu_hold),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        wr_q[$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic [7:0] byte_q[$];
    int         tests = 0;
    int         fails = 0;
    logic       busy_first = 1'b0;
    logic       hold_first = 1'b0;

    // Collect every write strobe and done pulse seen on the falling edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) wr_q.push_back('{mem_addr, mem_wdata});
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic make_stream(input int nwords);
        byte_q.delete();
        for (int i = 0; i < 4 * nwords; i++) byte_q.push_back(8'($urandom_range(0, 255)));
`ifdef INSTR_LOADER_CHECKSUM_EN
        add_csum(1'b0);
`endif
    endtask

    task automatic add_csum(input logic corrupt);
        logic [7:0] x;
        x = 8'h00;
        foreach (byte_q[i]) x = x ^ byte_q[i];
        byte_q.push_back(x ^ {7'd0, corrupt});
    endtask

    // Run one load: issue start, feed byte_q with random gaps, stop at done,
    // timeout, or (abort_at >= 0) once abort_at bytes have been accepted.
    task automatic run_load(input int len_v, input int stall_pct, input logic poke,
                            input int abort_at, output int done_rel, output logic timed_out);
        int   p;
        int   budget;
        int   dbase;
        int   start_edge;
        logic poked;
        p      = 0;
        budget = 0;
        poked  = 1'b0;
        dbase  = done_cnt;
        @(negedge clk);
        start      = 1'b1;
        len        = LEN_W'(len_v);
        start_edge = cyc + 1;
        while (done_cnt == dbase && budget < 4000) begin
            @(negedge clk);
            budget++;
            start = 1'b0;
            if (budget == 1) begin
                busy_first = busy;
                hold_first = cpu_hold;
            end
            if (abort_at >= 0 && p == abort_at) break;
            if (poke && !poked && p == 2) begin
                start = 1'b1;
                len   = LEN_W'(5);
                poked = 1'b1;
            end
            if (p < byte_q.size()) begin
                byte_valid = ($urandom_range(0, 99) >= stall_pct);
                byte_data  = byte_q[p];
                if (byte_valid && byte_ready) p++;
            end else begin
                byte_valid = 1'b0;
            end
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        timed_out  = (budget >= 4000);
        done_rel   = done_cyc - start_edge;
    endtask

    task automatic verify_writes(input string tag, input int base, input int n);
        logic [31:0] w;
        for (int k = 0; k < n; k++) begin
            if (base + k < wr_q.size()) begin
                w = (32'(byte_q[4*k]) << 24) | (32'(byte_q[4*k+1]) << 16) |
                    (32'(byte_q[4*k+2]) << 8) | 32'(byte_q[4*k+3]);
                chk($sformatf("%s_addr%0d", tag, k), wr_q[base+k].addr, 32'(4 * k));
                chk($sformatf("%s_data%0d", tag, k), wr_q[base+k].data, w);
            end else begin
                chk($sformatf("%s_missing%0d", tag, k), 32'(wr_q.size()), 32'(base + k + 1));
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int   rel;
        logic to;
        int   base;
        int   dbase;
        int   n0c;
        int   bad_len[2];

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed 2-word load, no stalls. Cycle 0 is the cycle start_i is
        // high, so done appears in cycle 5N+1 = rel + 1.
        byte_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h2A, 8'h40, 8'h20};
`ifdef INSTR_LOADER_CHECKSUM_EN
        add_csum(1'b0);
`endif
        base  = wr_q.size();
        dbase = done_cnt;
        run_load(2, 0, 1'b0, -1, rel, to);
        chk("t1_timeout", 32'(to), 32'd0);
        chk("t1_busy_rise", 32'(busy_first), 32'd1);
        chk("t1_hold_rise", 32'(hold_first), 32'd1);
        chk("t1_nwr", 32'(wr_q.size() - base), 32'd2);
        if (wr_q.size() >= base + 2) begin
            chk("t1_addr0", wr_q[base].addr, 32'h0);
            chk("t1_data0", wr_q[base].data, 32'h2008_0005);
            chk("t1_addr1", wr_q[base+1].addr, 32'h4);
            chk("t1_data1", wr_q[base+1].data, 32'h012A_4020);
        end
        chk("t1_done_cycle", 32'(rel + 1), 32'(5 * 2 + 1 + CSUM_EXTRA));
        chk("t1_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        chk("t1_done_pulses", 32'(done_cnt - dbase), 32'd1);
        chk("t1_done_low", 32'(done), 32'd0);
        chk("t1_busy_low", 32'(busy), 32'd0);
        chk("t1_hold_low", 32'(cpu_hold), 32'd0);

        // Out-of-range lengths: no writes, one done pulse, sticky error.
        bad_len[0] = 0;
        bad_len[1] = DEPTH + 1;
        for (int i = 0; i < 2; i++) begin
            byte_q.delete();
            base  = wr_q.size();
            dbase = done_cnt;
            run_load(bad_len[i], 0, 1'b0, -1, rel, to);
            chk($sformatf("t2_timeout_len%0d", bad_len[i]), 32'(to), 32'd0);
            chk($sformatf("t2_err_len%0d", bad_len[i]), 32'(err), 32'd1);
            repeat (5) @(negedge clk);
            chk($sformatf("t2_nwr_len%0d", bad_len[i]), 32'(wr_q.size() - base), 32'd0);
            chk($sformatf("t2_done_pulses_len%0d", bad_len[i]), 32'(done_cnt - dbase), 32'd1);
            chk($sformatf("t2_err_sticky_len%0d", bad_len[i]), 32'(err), 32'd1);
            chk($sformatf("t2_busy_len%0d", bad_len[i]), 32'(busy), 32'd0);
        end

        // Full-depth load with random source gaps; also clears the error.
        make_stream(DEPTH);
        base = wr_q.size();
        run_load(DEPTH, 30, 1'b0, -1, rel, to);
        chk("t3_timeout", 32'(to), 32'd0);
        chk("t3_err_cleared", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        chk("t3_nwr", 32'(wr_q.size() - base), 32'(DEPTH));
        verify_writes("t3", base, DEPTH);

        // Reset after 2 bytes of word 3: no write at 0xC, outputs at reset values.
        make_stream(4);
        base = wr_q.size();
        run_load(4, 20, 1'b0, 14, rel, to);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("t4_rst");
        @(negedge clk);
        rst = 1'b0;
        chk("t4_nwr", 32'(wr_q.size() - base), 32'd3);
        n0c = 0;
        for (int k = base; k < wr_q.size(); k++) if (wr_q[k].addr == 32'hC) n0c++;
        chk("t4_no_write_0xc", 32'(n0c), 32'd0);
        verify_writes("t4_partial", base, 3);
        @(negedge clk);
        make_stream(3);
        base = wr_q.size();
        run_load(3, 0, 1'b0, -1, rel, to);
        chk("t4_clean_timeout", 32'(to), 32'd0);
        chk("t4_clean_done_cycle", 32'(rel + 1), 32'(5 * 3 + 1 + CSUM_EXTRA));
        chk("t4_clean_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        chk("t4_clean_nwr", 32'(wr_q.size() - base), 32'd3);
        verify_writes("t4_clean", base, 3);

        // start_i pulsed (with a different length) during RECV is ignored.
        make_stream(2);
        base = wr_q.size();
        run_load(2, 0, 1'b1, -1, rel, to);
        chk("t5_timeout", 32'(to), 32'd0);
        chk("t5_done_cycle", 32'(rel + 1), 32'(5 * 2 + 1 + CSUM_EXTRA));
        repeat (3) @(negedge clk);
        chk("t5_nwr", 32'(wr_q.size() - base), 32'd2);
        chk("t5_busy", 32'(busy), 32'd0);
        verify_writes("t5", base, 2);

`ifdef INSTR_LOADER_CHECKSUM_EN
        // Checksum byte: 0x44 cancels 11^22^33^44, 0x45 does not.
        byte_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        run_load(1, 0, 1'b0, -1, rel, to);
        chk("t6_good_timeout", 32'(to), 32'd0);
        chk("t6_good_err", 32'(err), 32'd0);
        byte_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        run_load(1, 0, 1'b0, -1, rel, to);
        chk("t6_bad_timeout", 32'(to), 32'd0);
        chk("t6_bad_err", 32'(err), 32'd1);
        repeat (2) @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
